// File: rtl/ysyx_25040101_pkg.sv
// rtl/ysyx_25040101_pkg.sv - shared op codes, ALU controls and sequencer states
package ysyx_25040101_pkg;

    localparam logic [2:0] MD_MUL  = 3'd0;
    localparam logic [2:0] MD_DIV  = 3'd1;
    localparam logic [2:0] MD_DIVU = 3'd2;
    localparam logic [2:0] MD_REM  = 3'd3;
    localparam logic [2:0] MD_REMU = 3'd4;

    localparam logic [7:0] ALU_ADD = 8'h01;
    localparam logic [7:0] ALU_SUB = 8'h02;
    localparam logic [7:0] ALU_AND = 8'h04;
    localparam logic [7:0] ALU_OR  = 8'h08;
    localparam logic [7:0] ALU_XOR = 8'h10;
    localparam logic [7:0] ALU_SLL = 8'h20;
    localparam logic [7:0] ALU_SRL = 8'h40;
    localparam logic [7:0] ALU_SRA = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEG_A,
        ST_NEG_B,
        ST_ITER,
        ST_NEG_R,
        ST_DONE
    } md_state_t;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ysyx_25040101_muldiv_seq.sv
// rtl/ysyx_25040101_muldiv_seq.sv - iterative RV32M mul/div sequencer on the shared ALU
module ysyx_25040101_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_result_o,
    output logic            alu_busy_o,
    output logic [XLEN-1:0] alu_srca_o,
    output logic [XLEN-1:0] alu_srcb_o,
    output logic [7:0]      alu_ctrl_o,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            alu_borrow_i
);
    import ysyx_25040101_pkg::*;

    localparam logic [4:0] LAST = 5'(ITERS - 1);

    md_state_t       state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;    // MUL: multiplicand; divide: |a| then quotient
    logic [XLEN-1:0] b_q;    // MUL: multiplier; divide: |b|
    logic [XLEN-1:0] acc_q;  // MUL: accumulator; divide: partial remainder
    logic            neg_a;
    logic            neg_b;
    logic [4:0]      cnt;

    logic            is_mul;
    logic            qbit;
    logic            fix_needed;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] final_val;

    assign is_mul     = (op_q == MD_MUL);
    assign shifted    = {acc_q[XLEN-2:0], a_q[XLEN-1]};
    // Bit shifted out of rem makes the true value exceed 2^32, so subtract always fits.
    assign qbit       = acc_q[XLEN-1] | ~alu_borrow_i;
    assign div_rem    = qbit ? alu_result_i : shifted;
    assign div_quo    = {a_q[XLEN-2:0], qbit};
    assign fix_needed = ((op_q == MD_DIV) && (neg_a ^ neg_b)) || ((op_q == MD_REM) && neg_a);

    always_comb begin
        final_val = div_rem;
        if (is_mul)
            final_val = alu_result_i;
        else if (op_q == MD_DIV || op_q == MD_DIVU)
            final_val = div_quo;
    end

    always_comb begin
        alu_srca_o = '0;
        alu_srcb_o = '0;
        alu_ctrl_o = 8'h00;
        case (state)
            ST_NEG_A: begin
                alu_srcb_o = a_q;
                alu_ctrl_o = ALU_SUB;
            end
            ST_NEG_B: begin
                alu_srcb_o = b_q;
                alu_ctrl_o = ALU_SUB;
            end
            ST_ITER: begin
                if (is_mul) begin
                    alu_srca_o = acc_q;
                    alu_srcb_o = b_q[0] ? a_q : '0;
                    alu_ctrl_o = ALU_ADD;
                end else begin
                    alu_srca_o = shifted;
                    alu_srcb_o = b_q;
                    alu_ctrl_o = ALU_SUB;
                end
            end
            ST_NEG_R: begin
                alu_srcb_o = (op_q == MD_DIV) ? a_q : acc_q;
                alu_ctrl_o = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            req_ready_o   <= 1'b1;
            resp_valid_o  <= 1'b0;
            resp_result_o <= '0;
            alu_busy_o    <= 1'b0;
            op_q          <= MD_MUL;
            a_q           <= '0;
            b_q           <= '0;
            acc_q         <= '0;
            neg_a         <= 1'b0;
            neg_b         <= 1'b0;
            cnt           <= '0;
        end else if (flush_i) begin
            state        <= ST_IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            alu_busy_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        op_q        <= req_op_i;
                        a_q         <= req_a_i;
                        b_q         <= req_b_i;
                        acc_q       <= '0;
                        cnt         <= '0;
                        neg_a       <= is_signed_op(req_op_i) & req_a_i[XLEN-1];
                        neg_b       <= is_signed_op(req_op_i) & req_b_i[XLEN-1];
                        req_ready_o <= 1'b0;
                        // Fast paths enter DONE without a valid; it rises one cycle later.
                        if (req_op_i > MD_REMU) begin
                            resp_result_o <= '0;
                            state         <= ST_DONE;
                        end else if (req_op_i != MD_MUL && req_b_i == '0) begin
                            resp_result_o <= (req_op_i == MD_DIV || req_op_i == MD_DIVU) ? '1 : req_a_i;
                            state         <= ST_DONE;
                        end else if (is_signed_op(req_op_i) & req_a_i[XLEN-1]) begin
                            state      <= ST_NEG_A;
                            alu_busy_o <= 1'b1;
                        end else if (is_signed_op(req_op_i) & req_b_i[XLEN-1]) begin
                            state      <= ST_NEG_B;
                            alu_busy_o <= 1'b1;
                        end else begin
                            state      <= ST_ITER;
                            alu_busy_o <= 1'b1;
                        end
                    end
                end
                ST_NEG_A: begin
                    a_q   <= alu_result_i;
                    state <= neg_b ? ST_NEG_B : ST_ITER;
                end
                ST_NEG_B: begin
                    b_q   <= alu_result_i;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    cnt <= cnt + 5'd1;
                    if (is_mul) begin
                        acc_q <= alu_result_i;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                    end else begin
                        acc_q <= div_rem;
                        a_q   <= div_quo;
                    end
                    if (cnt == LAST) begin
                        if (fix_needed) begin
                            state <= ST_NEG_R;
                        end else begin
                            state         <= ST_DONE;
                            alu_busy_o    <= 1'b0;
                            resp_valid_o  <= 1'b1;
                            resp_result_o <= final_val;
                        end
                    end
                end
                ST_NEG_R: begin
                    resp_result_o <= alu_result_i;
                    state         <= ST_DONE;
                    alu_busy_o    <= 1'b0;
                    resp_valid_o  <= 1'b1;
                end
                ST_DONE: begin
                    if (!resp_valid_o) begin
                        resp_valid_o <= 1'b1;
                    end else if (resp_ready_i) begin
                        state        <= ST_IDLE;
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040101_muldiv_seq.sv
// tb/tb_ysyx_25040101_muldiv_seq.sv - randomized and directed bench for the mul/div sequencer
module tb_ysyx_25040101_muldiv_seq;
    import ysyx_25040101_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        alu_busy;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [7:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_borrow;

    int          tests = 0;
    int          fails = 0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_res = 32'd0;
    logic [2:0]  cur_op = 3'd0;

    always #5 clock = ~clock;

    // External shared ALU
    assign alu_result = (alu_ctrl == ALU_SUB) ? alu_srca - alu_srcb :
                        (alu_ctrl == ALU_ADD) ? alu_srca + alu_srcb : 32'd0;
    assign alu_borrow = alu_srca < alu_srcb;

    ysyx_25040101_muldiv_seq dut (
        .clock        (clock),
        .reset        (reset),
        .flush_i      (flush),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_result_o(resp_result),
        .alu_busy_o   (alu_busy),
        .alu_srca_o   (alu_srca),
        .alu_srcb_o   (alu_srcb),
        .alu_ctrl_o   (alu_ctrl),
        .alu_result_i (alu_result),
        .alu_borrow_i (alu_borrow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MD_MUL:  return a * b;
            MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REMU: return (b == 0) ? a : a % b;
            MD_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            MD_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        if (op > MD_REMU || (op != MD_MUL && b == 0)) return 1;
        n = 32;
        if (op == MD_DIV || op == MD_REM) n += int'(a[31]) + int'(b[31]);
        if (op == MD_DIV && (a[31] ^ b[31])) n++;
        if (op == MD_REM && a[31]) n++;
        return n;
    endfunction

    // Per-cycle output check against the expected response and ALU ownership
    always @(negedge clock) begin
        if (mon_en) begin
            if (resp_valid) begin
                chk("mon_result", resp_result, exp_res);
                chk("mon_ready_in_done", {31'd0, req_ready}, 32'd0);
            end
            if (alu_busy)
                chk("mon_busy_ctrl", {24'd0, alu_ctrl}, {24'd0, (cur_op == MD_MUL) ? ALU_ADD : ALU_SUB});
            else
                chk("mon_idle_ctrl", {24'd0, alu_ctrl}, 32'd0);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        exp_res   = ref_result(op, a, b);
        cur_op    = op;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic collect(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        int busy_cnt;
        int exp_lat;
        exp_lat  = ref_latency(op, a, b);
        lat      = 0;
        busy_cnt = 0;
        while (!resp_valid && lat < 200) begin
            if (alu_busy) busy_cnt++;
            @(posedge clock);
            #1 lat++;
        end
        chk("latency", lat, exp_lat);
        chk("result", resp_result, ref_result(op, a, b));
        chk("busy_cycles", busy_cnt, (exp_lat == 1) ? 0 : exp_lat);
    endtask

    task automatic release_resp(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        chk("after_handshake_valid", {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic run_dir(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lit, input int lit_lat, input int hold);
        int lat;
        issue(op, a, b);
        collect(op, a, b, lat);
        chk("literal_result", resp_result, lit);
        chk("literal_latency", lat, lit_lat);
        release_resp(hold);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic abort_test(input logic use_reset);
        issue(MD_MUL, 32'h1234_5678, 32'h9ABC_DEF1);
        repeat (10) @(posedge clock);
        #1;
        if (use_reset) reset = 1'b1;
        else flush = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        flush = 1'b0;
        chk("abort_busy", {31'd0, alu_busy}, 32'd0);
        chk("abort_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        run_dir(MD_MUL, 32'd3, 32'd4, 32'd12, 32, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset_result", resp_result, 32'd0);
        chk("reset_busy", {31'd0, alu_busy}, 32'd0);
        chk("reset_ctrl", {24'd0, alu_ctrl}, 32'd0);
        chk("reset_srca", alu_srca, 32'd0);
        chk("reset_srcb", alu_srcb, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        run_dir(MD_MUL,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 0);
        run_dir(MD_DIVU, 32'd100,       32'd7,         32'd14,        32, 1);
        run_dir(MD_REMU, 32'd100,       32'd7,         32'd2,         32, 0);
        run_dir(MD_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32, 2);
        run_dir(MD_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32, 0);
        run_dir(MD_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
        run_dir(MD_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
        run_dir(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
        run_dir(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         35, 0);
        run_dir(MD_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
        run_dir(MD_REM,  32'd5,         32'd0,         32'd5,         1,  0);
        run_dir(3'd6,    32'd9,         32'd3,         32'd0,         1,  0);

        // Backpressure with a competing request held during the stall
        issue(MD_MUL, 32'd7, 32'hFFFF_FFFD);
        collect(MD_MUL, 32'd7, 32'hFFFF_FFFD, lat);
        req_op    = MD_DIVU;
        req_a     = 32'd100;
        req_b     = 32'd7;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_result", resp_result, 32'hFFFF_FFEB);
        end
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        chk("bp_hs_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_hs_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_hs_busy", {31'd0, alu_busy}, 32'd0);
        issue(MD_DIVU, 32'd100, 32'd7);
        collect(MD_DIVU, 32'd100, 32'd7, lat);
        chk("bp_next_result", resp_result, 32'd14);
        release_resp(0);

        abort_test(1'b0);
        abort_test(1'b1);

        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            a  = rand_operand();
            b  = rand_operand();
            issue(op, a, b);
            collect(op, a, b, lat);
            release_resp($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
